pq_cmd_sequencer: RTL and testbench
===================================

# pq_cmd_sequencer

Upstream command sequencer for the systolic-array priority queue (min-queue, empty root reads all-ones). It accepts independent push and pop request streams over valid/ready handshakes and buffers pushes in a small FIFO. It merges a coincident push and pop into a single replace, and issues one-cycle `wrt`/`read` pulses to the queue, holding the queue-mandated idle gap after each. Popped roots return on a valid-qualified response port.

## Interface
- `DATA_WIDTH`, 16, key width; must match the queue.
- `FIFO_DEPTH`, 4, push-buffer entries; power of two, ≥2.
- `ENQ_GAP`, 2, idle cycles after an enqueue.
- `DEQ_GAP`, 3, idle cycles after a dequeue.
- `REP_GAP`, 2, idle cycles after a replace.
- `i_CLK`  in  1  clock, rising edge.
- `i_RST`  in  1  synchronous, active-high reset.
- `i_push_valid`  in  1  push request.
- `o_push_ready`  out  1  FIFO not full; a push transfers when valid and ready are both high at the edge.
- `i_push_data`  in  DATA_WIDTH  key to insert.
- `i_pop_valid`  in  1  pop request.
- `o_pop_ready`  out  1  high when no pop is pending.
- `o_pop_data_valid`  out  1  one-cycle response strobe.
- `o_pop_data`  out  DATA_WIDTH  popped key; all-ones if the queue was empty.
- `o_pop_empty`  out  1  qualifies the response: the pop found the queue empty.
- `o_pq_wrt` / `o_pq_read`  out  1  queue command pulses.
- `o_pq_data`  out  DATA_WIDTH  key sent to the queue.
- `i_pq_full` / `i_pq_empty`  in  1  queue status.
- `i_pq_data`  in  DATA_WIDTH  current queue root.
- `o_busy`  out  1  FSM not in S_IDLE, or FIFO non-empty, or pop pending.

## Operation
- Push FIFO:
  - Written on a push handshake.
  - Head is visible the cycle after write.
  - No bypass.
- Pop pending register:
  - Set on a pop handshake.
  - Cleared when the pop is serviced.
- FSM states are S_IDLE, S_GAP.
- Decisions in S_IDLE use the registered state at the edge, evaluated in priority order:
  1. Pop pending and `i_pq_empty` → no command. Respond with `o_pop_data`='1, `o_pop_empty`=1, and clear the pending pop. A pending push is handled on a later cycle. Stay in S_IDLE.
  2. Pop pending, FIFO non-empty, queue not empty → REPLACE (`wrt`=`read`=1, `o_pq_data`=FIFO head). Pop the FIFO, respond with `i_pq_data`, go to S_GAP with REP_GAP. This is legal when the queue is full.
  3. Pop pending only → DEQUEUE (`read`=1). Respond with `i_pq_data`, go to S_GAP with DEQ_GAP.
  4. FIFO non-empty and `!i_pq_full` → ENQUEUE (`wrt`=1). Pop the FIFO, go to S_GAP with ENQ_GAP.
  5. FIFO non-empty and full → stall in S_IDLE (no command). `o_push_ready` drops once the FIFO fills.
- The returned key is always the pre-operation root. A replaced-in key is never returned by the same replace.
- S_GAP:
  - The counter decrements each cycle; return to S_IDLE when it reaches 1.
  - Queue status inputs are ignored while in S_GAP.
  - New requests are still accepted if ready.
- `o_pq_data` holds its last value when no enqueue or replace is issued.

## Timing
- Reset values:
  - `o_pq_wrt`, `o_pq_read`, `o_pop_data_valid`, `o_pop_empty`, `o_busy`, `o_pop_data`, `o_pq_data` are 0.
  - `o_push_ready`=0 and `o_pop_ready`=0 while `i_RST` is high; both are 1 the first cycle after.
  - FIFO is empty, no pop pending, FSM in S_IDLE.
- Reset mid-gap or with a pending pop aborts everything. No response is generated. The queue is reset by its own (separately mapped) reset.
- All outputs are registered. Command pulses are exactly one cycle wide.
- Pop accepted at edge k → command and response both registered at edge k+1. `o_pq_read` and `o_pop_data_valid` are high in the same cycle.
- Push accepted at edge k → earliest ENQUEUE at edge k+1.
- Minimum command spacing is gap+1 cycles:
  - enqueue-to-next-command ≥3 cycles;
  - dequeue ≥4 cycles;
  - replace ≥3 cycles.
- Simultaneous push and pop handshakes at the same edge are both accepted. The next decision is a REPLACE if the queue is non-empty.
- The FIFO pointer uses a wrap-around counter of width $clog2(FIFO_DEPTH)+1. Full and empty are derived from the pointer MSB.

## Structure
- `pq_seq_pkg` holds:
  - `typedef enum logic {S_IDLE, S_GAP} state_t`;
  - `typedef enum logic [1:0] {OP_NONE, OP_ENQ, OP_DEQ, OP_REP} op_t` (also used by the bench);
  - default gap constants.
- One sub-module, `pq_push_fifo`:
  - synchronous FIFO with DATA_WIDTH and FIFO_DEPTH parameters;
  - ports for push/pop, head, full/empty.
- FSM, gap counter and pop register live in `pq_cmd_sequencer`.

## Test plan
- Reset, then push 300, 5, 900 back-to-back → three ENQUEUE pulses, each spaced exactly 3 cycles, with `o_pq_data` = 300, 5, 900. `o_push_ready` stays high.
- Pop with the queue model empty → `o_pop_data_valid` with `o_pop_data`=16'hFFFF and `o_pop_empty`=1. No `o_pq_read` pulse.
- Queue root 5, then pop → `o_pq_read` and response 5 in the same cycle. The next command is no earlier than 4 cycles later.
- Push 42 and pop in the same edge, root 5 → single REPLACE (`wrt`=`read`=1, `o_pq_data`=42) with response 5.
- `i_pq_full`=1, push 5 keys → FIFO fills and `o_push_ready`=0 after 4 keys. No enqueue is issued. Deassert full → the 4 buffered keys drain in order.
- Assert `i_RST` during S_GAP with a pop pending → all outputs go to 0. No response. `o_busy`=0 the cycle after.

Source files
------------

// File: rtl/pq_seq_pkg.sv
// pq_seq_pkg: shared types and default gap timing for the priority-queue command sequencer
package pq_seq_pkg;
  typedef enum logic {S_IDLE, S_GAP} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_ENQ, OP_DEQ, OP_REP} op_t;
  localparam int DEF_ENQ_GAP = 2;
  localparam int DEF_DEQ_GAP = 3;
  localparam int DEF_REP_GAP = 2;
endpackage

// File: rtl/pq_push_fifo.sv
// pq_push_fifo: power-of-two synchronous FIFO buffering keys until they are enqueued
module pq_push_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty,
  output logic                  full_nxt,
  output logic                  empty_nxt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] WRAP = {1'b1, {AW{1'b0}}};
  logic [AW:0] wr, rd, wr_nxt, rd_nxt;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  always_comb begin
    wr_nxt = wr + {{AW{1'b0}}, push};
    rd_nxt = rd + {{AW{1'b0}}, pop};
    full = (wr ^ rd) == WRAP;
    empty = wr == rd;
    full_nxt = (wr_nxt ^ rd_nxt) == WRAP;
    empty_nxt = wr_nxt == rd_nxt;
    head = mem[rd[AW-1:0]];
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr <= '0;
      rd <= '0;
    end else begin
      wr <= wr_nxt;
      rd <= rd_nxt;
    end
  end
  always_ff @(posedge CLK) begin
    if (push) mem[wr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/pq_cmd_sequencer.sv
// pq_cmd_sequencer: merges push/pop streams into gapped enqueue/dequeue/replace pulses for the priority queue
module pq_cmd_sequencer
  import pq_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int ENQ_GAP = DEF_ENQ_GAP,
  parameter int DEQ_GAP = DEF_DEQ_GAP,
  parameter int REP_GAP = DEF_REP_GAP
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_push_valid,
  output logic                  o_push_ready,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop_valid,
  output logic                  o_pop_ready,
  output logic                  o_pop_data_valid,
  output logic [DATA_WIDTH-1:0] o_pop_data,
  output logic                  o_pop_empty,
  output logic                  o_pq_wrt,
  output logic                  o_pq_read,
  output logic [DATA_WIDTH-1:0] o_pq_data,
  input  logic                  i_pq_full,
  input  logic                  i_pq_empty,
  input  logic [DATA_WIDTH-1:0] i_pq_data,
  output logic                  o_busy
);
  localparam int GW = 8;
  logic push_hs, pop_hs, fifo_pop, fifo_full, fifo_empty, full_nxt, empty_nxt;
  logic pop_pend, pop_pend_nxt, resp_empty, serviced;
  logic [DATA_WIDTH-1:0] head;
  logic [GW-1:0] cnt, cnt_nxt;
  state_t state, state_nxt;
  op_t op;
  assign push_hs = i_push_valid && o_push_ready;
  assign pop_hs = i_pop_valid && o_pop_ready;
  pq_push_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .CLK(i_CLK),
    .RST(i_RST),
    .push(push_hs && !fifo_full),
    .pop(fifo_pop),
    .din(i_push_data),
    .head(head),
    .full(fifo_full),
    .empty(fifo_empty),
    .full_nxt(full_nxt),
    .empty_nxt(empty_nxt)
  );
  always_comb begin
    resp_empty = state == S_IDLE && pop_pend && i_pq_empty;
    op = (state != S_IDLE || resp_empty) ? OP_NONE :
         pop_pend ? (fifo_empty ? OP_DEQ : OP_REP) :
         (!fifo_empty && !i_pq_full) ? OP_ENQ : OP_NONE;
    serviced = resp_empty || op == OP_DEQ || op == OP_REP;
    fifo_pop = op == OP_ENQ || op == OP_REP;
    pop_pend_nxt = pop_hs || (pop_pend && !serviced);
    state_nxt = op != OP_NONE ? S_GAP : (state == S_GAP && cnt == GW'(1)) ? S_IDLE : state;
    cnt_nxt = op == OP_ENQ ? GW'(ENQ_GAP) :
              op == OP_DEQ ? GW'(DEQ_GAP) :
              op == OP_REP ? GW'(REP_GAP) :
              state == S_GAP ? cnt - GW'(1) : cnt;
  end
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state <= S_IDLE;
      cnt <= '0;
      pop_pend <= 1'b0;
      o_push_ready <= 1'b0;
      o_pop_ready <= 1'b0;
      o_pop_data_valid <= 1'b0;
      o_pop_data <= '0;
      o_pop_empty <= 1'b0;
      o_pq_wrt <= 1'b0;
      o_pq_read <= 1'b0;
      o_pq_data <= '0;
      o_busy <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      pop_pend <= pop_pend_nxt;
      o_push_ready <= !full_nxt;
      o_pop_ready <= !pop_pend_nxt;
      o_pop_data_valid <= serviced;
      o_pop_empty <= resp_empty;
      o_pq_wrt <= op == OP_ENQ || op == OP_REP;
      o_pq_read <= op == OP_DEQ || op == OP_REP;
      o_busy <= state_nxt != S_IDLE || !empty_nxt || pop_pend_nxt;
      if (serviced) o_pop_data <= resp_empty ? '1 : i_pq_data;
      if (fifo_pop) o_pq_data <= head;
    end
  end
endmodule

// File: tb/tb_pq_cmd_sequencer.sv
// tb_pq_cmd_sequencer: vector table, corner sequences and random traffic against a queue-level reference model
module tb_pq_cmd_sequencer;
  import pq_seq_pkg::*;
  localparam int CAP = 8;
  typedef struct {
    logic        push_v;
    logic [15:0] push_d;
    logic        pop_v;
    logic        wrt;
    logic        rd;
    logic [15:0] pqd;
    logic        vld;
    logic [15:0] pd;
    logic        emp;
  } vec_t;
  logic clk = 0, rst = 1;
  logic push_valid = 0, pop_valid = 0;
  logic [15:0] push_data = 0;
  logic pq_full = 0, pq_empty = 1;
  logic [15:0] pq_data = 16'hFFFF;
  logic push_ready, pop_ready, pop_data_valid, pop_empty, pq_wrt, pq_read, busy;
  logic [15:0] pop_data, pq_wdata;
  int errors = 0, checks = 0, cyc = 0, last_c = -100, last_g = 0, pend = 0;
  int pushq[$];
  int pq[$];
  logic [15:0] last_key = 0;
  logic force_full = 0;
  op_t got;
  pq_cmd_sequencer dut (
    .i_CLK(clk),
    .i_RST(rst),
    .i_push_valid(push_valid),
    .o_push_ready(push_ready),
    .i_push_data(push_data),
    .i_pop_valid(pop_valid),
    .o_pop_ready(pop_ready),
    .o_pop_data_valid(pop_data_valid),
    .o_pop_data(pop_data),
    .o_pop_empty(pop_empty),
    .o_pq_wrt(pq_wrt),
    .o_pq_read(pq_read),
    .o_pq_data(pq_wdata),
    .i_pq_full(pq_full),
    .i_pq_empty(pq_empty),
    .i_pq_data(pq_data),
    .o_busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [31:0] g, logic [31:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, g, e, cyc);
    end
  endtask
  task automatic drive_pq();
    pq_empty = pq.size() == 0;
    pq_full = force_full || pq.size() >= CAP;
    pq_data = pq.size() == 0 ? 16'hFFFF : 16'(pq[0]);
  endtask
  task automatic pq_insert(int k);
    int i = 0;
    while (i < pq.size() && pq[i] <= k) i++;
    pq.insert(i, k);
  endtask
  task automatic clear_model();
    pq.delete();
    pushq.delete();
    pend = 0;
    last_c = -100;
    last_g = 0;
    last_key = 0;
    force_full = 0;
    drive_pq();
  endtask
  task automatic step();
    logic pf, qf, idle, ev, ee;
    op_t eo;
    int ek;
    logic [15:0] er;
    pf = push_valid && push_ready;
    qf = pop_valid && pop_ready;
    idle = cyc + 1 - last_c > last_g;
    eo = OP_NONE;
    ev = 0;
    ee = 0;
    er = 16'hFFFF;
    ek = 0;
    if (idle && pend > 0 && pq.size() == 0) begin
      ev = 1;
      ee = 1;
    end else if (idle && pend > 0) begin
      eo = pushq.size() > 0 ? OP_REP : OP_DEQ;
      ev = 1;
      er = 16'(pq[0]);
    end else if (idle && pushq.size() > 0 && !pq_full) eo = OP_ENQ;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    got = pq_wrt && pq_read ? OP_REP : pq_wrt ? OP_ENQ : pq_read ? OP_DEQ : OP_NONE;
    chk("op", 32'(got), 32'(eo));
    if (eo == OP_ENQ || eo == OP_REP) begin
      ek = pushq.pop_front();
      last_key = 16'(ek);
    end
    chk("pq_data", 32'(pq_wdata), 32'(last_key));
    if (eo == OP_DEQ || eo == OP_REP) void'(pq.pop_front());
    if (eo == OP_ENQ || eo == OP_REP) pq_insert(ek);
    if (eo != OP_NONE) begin
      last_c = cyc;
      last_g = eo == OP_DEQ ? 3 : 2;
    end
    chk("pop_valid", 32'(pop_data_valid), 32'(ev));
    if (ev) begin
      chk("pop_data", 32'(pop_data), 32'(er));
      chk("pop_empty", 32'(pop_empty), 32'(ee));
      pend--;
    end
    if (pf) pushq.push_back(int'(push_data));
    if (qf) pend++;
    chk("push_ready", 32'(push_ready), 32'(pushq.size() < 4));
    chk("pop_ready", 32'(pop_ready), 32'(pend == 0));
    chk("busy", 32'(busy), 32'(pend > 0 || pushq.size() > 0 || cyc - last_c < last_g));
    drive_pq();
  endtask
  task automatic chk_zero(string name);
    chk({name, "_ctl"}, 32'({pq_wrt, pq_read, pop_data_valid, pop_empty, busy, push_ready, pop_ready}), 32'd0);
    chk({name, "_pop_data"}, 32'(pop_data), 32'd0);
    chk({name, "_pq_data"}, 32'(pq_wdata), 32'd0);
  endtask
  initial begin
    vec_t tbl[22];
    int kq[$];
    int cq[$];
    tbl[0]  = '{0, 0,   1, 0, 0, 0,   0, 0,      0};
    tbl[1]  = '{0, 0,   0, 0, 0, 0,   1, 16'hFFFF, 1};
    tbl[2]  = '{1, 300, 0, 0, 0, 0,   0, 0,      0};
    tbl[3]  = '{1, 5,   0, 1, 0, 300, 0, 0,      0};
    tbl[4]  = '{1, 900, 0, 0, 0, 0,   0, 0,      0};
    tbl[5]  = '{0, 0,   0, 0, 0, 0,   0, 0,      0};
    tbl[6]  = '{0, 0,   0, 1, 0, 5,   0, 0,      0};
    tbl[7]  = '{0, 0,   0, 0, 0, 0,   0, 0,      0};
    tbl[8]  = '{0, 0,   0, 0, 0, 0,   0, 0,      0};
    tbl[9]  = '{0, 0,   0, 1, 0, 900, 0, 0,      0};
    tbl[10] = '{0, 0,   1, 0, 0, 0,   0, 0,      0};
    tbl[11] = '{0, 0,   0, 0, 0, 0,   0, 0,      0};
    tbl[12] = '{0, 0,   0, 0, 1, 0,   1, 5,      0};
    tbl[13] = '{1, 5,   0, 0, 0, 0,   0, 0,      0};
    tbl[14] = '{0, 0,   0, 0, 0, 0,   0, 0,      0};
    tbl[15] = '{0, 0,   0, 0, 0, 0,   0, 0,      0};
    tbl[16] = '{0, 0,   0, 1, 0, 5,   0, 0,      0};
    tbl[17] = '{1, 42,  1, 0, 0, 0,   0, 0,      0};
    tbl[18] = '{0, 0,   0, 0, 0, 0,   0, 0,      0};
    tbl[19] = '{0, 0,   0, 1, 1, 42,  1, 5,      0};
    tbl[20] = '{0, 0,   0, 0, 0, 0,   0, 0,      0};
    tbl[21] = '{0, 0,   0, 0, 0, 0,   0, 0,      0};
    rst = 1;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("rst");
    rst = 0;
    step();
    for (int r = 0; r < 22; r++) begin
      push_valid = tbl[r].push_v;
      push_data = tbl[r].push_d;
      pop_valid = tbl[r].pop_v;
      step();
      chk($sformatf("t%0d_wrt", r), 32'(pq_wrt), 32'(tbl[r].wrt));
      chk($sformatf("t%0d_read", r), 32'(pq_read), 32'(tbl[r].rd));
      chk($sformatf("t%0d_valid", r), 32'(pop_data_valid), 32'(tbl[r].vld));
      if (tbl[r].wrt) chk($sformatf("t%0d_pq_data", r), 32'(pq_wdata), 32'(tbl[r].pqd));
      if (tbl[r].vld) begin
        chk($sformatf("t%0d_pop_data", r), 32'(pop_data), 32'(tbl[r].pd));
        chk($sformatf("t%0d_pop_empty", r), 32'(pop_empty), 32'(tbl[r].emp));
      end
    end
    push_valid = 0;
    pop_valid = 0;
    force_full = 1;
    drive_pq();
    for (int i = 0; i < 6; i++) begin
      push_valid = 1;
      push_data = 16'(11 + pushq.size());
      step();
    end
    chk("stall_ready", 32'(push_ready), 32'd0);
    push_valid = 0;
    force_full = 0;
    drive_pq();
    for (int i = 0; i < 20; i++) begin
      step();
      if (pq_wrt) begin
        kq.push_back(int'(pq_wdata));
        cq.push_back(cyc);
      end
    end
    chk("drain_count", 32'(kq.size()), 32'd4);
    for (int i = 0; i < kq.size() && i < 4; i++) chk("drain_key", 32'(kq[i]), 32'(11 + i));
    for (int i = 1; i < cq.size(); i++) chk("drain_spacing", 32'(cq[i] - cq[i-1]), 32'd3);
    push_valid = 1;
    push_data = 16'd7;
    step();
    push_valid = 0;
    step();
    pop_valid = 1;
    step();
    pop_valid = 0;
    chk("mid_pending", 32'(pop_ready), 32'd0);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk_zero("mid_rst");
    rst = 0;
    clear_model();
    step();
    chk("mid_after_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3000; i++) begin
      push_valid = ($urandom % 3) == 0;
      push_data = 16'($urandom);
      pop_valid = ($urandom % 4) == 0;
      if ($urandom % 40 == 0) force_full = !force_full;
      drive_pq();
      step();
    end
    push_valid = 0;
    force_full = 0;
    drive_pq();
    for (int i = 0; i < 400 && (pushq.size() > 0 || pend > 0); i++) begin
      pop_valid = pushq.size() > 0 && pq.size() >= CAP;
      step();
    end
    pop_valid = 0;
    repeat (5) step();
    chk("drained", 32'(pushq.size() + pend), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
